// File: rtl/fpu_issue.sv
// Core-side issuer for the FPU en/ready handshake: one FP op in flight, unsupported opcodes rejected.
// Latency: response N+3 cycles after accept for an FPU of N stages; 1 cycle for a rejected opcode.
// Backpressure: req_ready low from accept until the response is taken; response held while resp_ready is low.
module fpu_issue #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic [3:0]       fpu_ctl,
    output logic [31:0]      fpu_x1,
    output logic [31:0]      fpu_x2,
    output logic             fpu_en,
    input  logic             fpu_ready,
    input  logic [31:0]      fpu_y,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            op_ok;
    logic            accept;
    logic            wd_hit;

    always_comb begin
        op_ok = 1'b1;
        case (req_op)
            4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd15: op_ok = 1'b0;
            default:                               op_ok = 1'b1;
        endcase
    end

    // req_ready is registered, so it is only ever high while in IDLE
    assign accept = req_valid && req_ready;
    // This WAIT cycle is the TIMEOUT-th one without a completion
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = op_ok ? ISSUE : RESP;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (fpu_ready || wd_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fpu_en     = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            ISSUE:   fpu_en = 1'b1;
            WAIT:    fpu_en = 1'b0;
            RESP:    resp_valid = 1'b1;
            default: busy = 1'b1;
        endcase
    end

    // Operands and opcode stay put through WAIT and RESP: the FPU picks its result by ctl at completion
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b0;
            fpu_ctl   <= '0;
            fpu_x1    <= '0;
            fpu_x2    <= '0;
            resp_tag  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        fpu_ctl   <= req_op;
                        fpu_x1    <= req_a;
                        fpu_x2    <= req_b;
                        resp_tag  <= req_tag;
                        resp_data <= '0;
                        resp_err  <= ~op_ok;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (fpu_ready) begin
                        resp_data <= fpu_y;
                        resp_err  <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if (wd_hit) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: behavioural FPU stub with per-opcode latency plus directed and random operations.
module tb_fpu_issue;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 31;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic [3:0]       fpu_ctl;
    logic [31:0]      fpu_x1;
    logic [31:0]      fpu_x2;
    logic             fpu_en;
    logic             fpu_ready;
    logic [31:0]      fpu_y;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic        stub_rdy;
    logic [31:0] stub_y;
    int          stub_cnt;
    int          stub_force_n = -1;
    bit          stub_dead = 1'b0;
    logic        inj = 1'b0;

    assign fpu_ready = stub_rdy | inj;
    assign fpu_y     = stub_y;

    always #5 clk = ~clk;

    fpu_issue #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_err(resp_err),
        .fpu_ctl(fpu_ctl), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2), .fpu_en(fpu_en),
        .fpu_ready(fpu_ready), .fpu_y(fpu_y), .busy(busy)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(f[30:23]) - 11'd127 + 11'd1023;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52];
        if (e == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(e - 11'd1023 + 11'd127), d[51:29]};
    endfunction

    function automatic bit op_sup(input logic [3:0] op);
        return !(op inside {4'd6, 4'd7, 4'd8, 4'd13, 4'd14, 4'd15});
    endfunction

    function automatic int lat_n(input logic [3:0] op);
        case (op)
            4'd0, 4'd1: return 2;
            4'd2:       return 3;
            4'd3:       return 4;
            4'd4:       return 9;
            default:    return 0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return op_sup(op) ? lat_n(op) + 3 : 1;
    endfunction

    function automatic logic [31:0] fpu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return r2f(f2r(a) + f2r(b));
            4'd1:    return r2f(f2r(a) - f2r(b));
            4'd2:    return r2f(f2r(a) * f2r(b));
            4'd3:    return r2f(1.0 / f2r(a));
            4'd4:    return r2f(f2r(a) / f2r(b));
            4'd5:    return r2f(f2r(a) / 2.0);
            4'd9:    return (f2r(a) == f2r(b)) ? 32'd1 : 32'd0;
            4'd10:   return (f2r(a) <= f2r(b)) ? 32'd1 : 32'd0;
            4'd11:   return a & 32'h7FFF_FFFF;
            4'd12:   return a ^ 32'h8000_0000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick_n(input logic [3:0] op);
        return (stub_force_n >= 0) ? stub_force_n : lat_n(op);
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // FPU stand-in: ready pulses N+1 cycles after en, result taken from the operands present at completion
    always @(posedge clk) begin
        if (rst) begin
            stub_rdy <= 1'b0;
            stub_cnt <= 0;
            stub_y   <= '0;
        end else begin
            stub_rdy <= 1'b0;
            if (fpu_en && !stub_dead) begin
                if (pick_n(fpu_ctl) == 0) begin
                    stub_rdy <= 1'b1;
                    stub_y   <= fpu_model(fpu_ctl, fpu_x1, fpu_x2);
                end else begin
                    stub_cnt <= pick_n(fpu_ctl);
                end
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
                if (stub_cnt == 1) begin
                    stub_rdy <= 1'b1;
                    stub_y   <= fpu_model(fpu_ctl, fpu_x1, fpu_x2);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int hold, input int exp_lat, input bit exp_err,
                         input bit inj_issue);
        logic [31:0] exp_y;
        int          k;
        int          en_cnt;
        bit          en_first;
        bit          rdy_seen;
        exp_y    = exp_err ? 32'd0 : fpu_model(op, a, b);
        en_cnt   = 0;
        en_first = 1'b0;
        rdy_seen = 1'b0;
        @(negedge clk);
        check({name, ".req_ready_idle"}, 128'(req_ready), 128'(1));
        req_valid  = 1'b1;
        req_op     = op;
        req_a      = a;
        req_b      = b;
        req_tag    = tag;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_op    = 4'($urandom);
        req_tag   = TAG_W'($urandom);
        if (inj_issue) inj = 1'b1;
        k = 0;
        while (k < 200) begin
            k++;
            @(negedge clk);
            if (fpu_en) begin
                en_cnt++;
                if (k == 1) en_first = 1'b1;
            end
            if (req_ready) rdy_seen = 1'b1;
            if (resp_valid) break;
            if (k == 1 && inj) begin
                @(posedge clk);
                #1 inj = 1'b0;
            end
        end
        inj = 1'b0;
        check({name, ".latency"}, 128'(k), 128'(exp_lat));
        check({name, ".en_pulses"}, 128'(en_cnt), 128'(op_sup(op) ? 1 : 0));
        if (op_sup(op)) check({name, ".en_in_cycle1"}, 128'(en_first), 128'(1));
        check({name, ".req_ready_busy"}, 128'(rdy_seen), 128'(0));
        check({name, ".data"}, 128'(resp_data), 128'(exp_y));
        check({name, ".tag"}, 128'(resp_tag), 128'(tag));
        check({name, ".err"}, 128'(resp_err), 128'(exp_err));
        for (int h = 0; h < hold; h++) begin
            if (h == 0) inj = 1'b1;
            @(posedge clk);
            #1 inj = 1'b0;
            @(negedge clk);
            check({name, ".hold_resp"}, {94'd0, resp_valid, req_ready, resp_data}, {94'd0, 1'b1, 1'b0, exp_y});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check({name, ".after_accept"}, {125'd0, resp_valid, req_ready, busy}, {125'd0, 3'b010});
    endtask

    initial begin
        int k;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.outputs",
              {22'd0, req_ready, resp_valid, resp_data, resp_tag, resp_err, fpu_ctl, fpu_x1, fpu_x2, fpu_en, busy},
              128'd0);
        rst = 1'b0;
        check("reset.req_ready_same_cycle", 128'(req_ready), 128'(0));
        @(negedge clk);
        check("reset.req_ready_next", 128'(req_ready), 128'(1));

        do_op("fadd", 4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd3, 0, 5, 1'b0, 1'b0);
        check("fadd.value", 128'(resp_data), 128'(32'h4040_0000));
        do_op("fle_gt", 4'd10, 32'h4000_0000, 32'h3F80_0000, 5'd4, 0, 3, 1'b0, 1'b0);
        do_op("fle_lt", 4'd10, 32'h3F80_0000, 32'h4000_0000, 5'd5, 0, 3, 1'b0, 1'b0);
        check("fle_lt.value", 128'(resp_data), 128'(1));
        do_op("feq_same", 4'd9, 32'h4049_0FDB, 32'h4049_0FDB, 5'd6, 0, 3, 1'b0, 1'b0);
        do_op("bad_op7", 4'd7, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 0, 1, 1'b1, 1'b0);
        do_op("fdiv_hold", 4'd4, 32'h40C0_0000, 32'h4000_0000, 5'd8, 4, 12, 1'b0, 1'b1);
        check("fdiv.value", 128'(resp_data), 128'(32'h4040_0000));

        @(negedge clk);
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        @(negedge clk);
        check("idle_stray_ready", {125'd0, busy, resp_valid, req_ready}, {125'd0, 3'b001});

        stub_dead = 1'b1;
        do_op("timeout", 4'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd9, 1, TIMEOUT + 2, 1'b1, 1'b0);
        stub_dead = 1'b0;
        stub_force_n = TIMEOUT - 1;
        do_op("ready_vs_timeout", 4'd2, 32'h4000_0000, 32'h4040_0000, 5'd10, 0, TIMEOUT + 2, 1'b0, 1'b0);
        stub_force_n = TIMEOUT;
        do_op("ready_too_late", 4'd2, 32'h4000_0000, 32'h4040_0000, 5'd11, 1, TIMEOUT + 2, 1'b1, 1'b0);
        stub_force_n = -1;
        repeat (3) @(negedge clk);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd4;
        req_a     = 32'h40C0_0000;
        req_b     = 32'h4000_0000;
        req_tag   = 5'd12;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midop.busy", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_reset.outputs",
              {22'd0, req_ready, resp_valid, resp_data, resp_tag, resp_err, fpu_ctl, fpu_x1, fpu_x2, fpu_en, busy},
              128'd0);
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (resp_valid || busy) k++;
        end
        check("midop_reset.no_response", 128'(k), 128'(0));
        do_op("fhalf", 4'd5, 32'h4000_0000, 32'h0000_0000, 5'd13, 0, 3, 1'b0, 1'b0);
        check("fhalf.value", 128'(resp_data), 128'(32'h3F80_0000));

        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = rnd_f();
            b  = rnd_f();
            do_op("random", op, a, b, TAG_W'($urandom), int'($urandom_range(0, 2)),
                  ref_lat(op), !op_sup(op), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
